// File: rtl/lampFPU_pkg.sv
// Shared lampFPU definitions: 16-bit float layout, special encodings and the
// sqrt issue-controller state type.
package lampFPU_pkg;

  localparam int LAMP_FLOAT_DW     = 16;
  localparam int LAMP_FLOAT_E_DW   = 8;
  localparam int LAMP_FLOAT_F_DW   = 7;
  localparam int LAMP_FLOAT_E_BIAS = 127;

  localparam logic [15:0] QNAN_16 = 16'h7FC0;
  localparam logic [15:0] PINF_16 = 16'h7F80;
  localparam logic [15:0] NINF_16 = 16'hFF80;

  localparam logic [2:0] FLAG_TIMEOUT = 3'b100;
  localparam logic [2:0] FLAG_DBZ     = 3'b010;
  localparam logic [2:0] FLAG_INVALID = 3'b001;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} sqrt_ctrl_ss_t;

endpackage

// File: rtl/lamp_sqrt_classify.sv
// Combinational operand classifier for sqrt / 1/sqrt: special-case result and
// flags, biased result exponent and the odd-exponent flag for the core.
module lamp_sqrt_classify
  import lampFPU_pkg::*;
(
  input  logic [15:0] op_i,
  input  logic        inv_i,
  output logic        special_o,
  output logic [15:0] special_res_o,
  output logic [2:0]  special_flags_o,
  output logic [7:0]  res_e_o,
  output logic        exp_odd_o
);

  logic              sign;
  logic [7:0]        e;
  logic [6:0]        f;
  logic [8:0]        sqrt_sum;
  logic signed [9:0] unb_e;
  logic signed [9:0] inv_e;
  logic              unused_bits;

  assign sign = op_i[15];
  assign e    = op_i[14:7];
  assign f    = op_i[6:0];

  // Odd unbiased exponent means an even biased one; the halving below floors.
  assign exp_odd_o   = ~e[0];
  assign sqrt_sum    = {1'b0, e} + 9'd127;
  assign unb_e       = $signed({2'b00, e}) - 10'sd127;
  assign inv_e       = 10'sd127 - (unb_e >>> 1);
  assign res_e_o     = inv_i ? inv_e[7:0] : sqrt_sum[8:1];
  assign unused_bits = ^{sqrt_sum[0], inv_e[9:8]};

  always_comb begin
    special_o       = 1'b1;
    special_res_o   = QNAN_16;
    special_flags_o = FLAG_INVALID;
    if (e == 8'h00) begin
      if (inv_i) begin
        special_res_o   = sign ? NINF_16 : PINF_16;
        special_flags_o = FLAG_DBZ;
      end else begin
        special_res_o   = {sign, 15'h0000};
        special_flags_o = 3'b000;
      end
    end else if ((e == 8'hFF) && (f != 7'd0)) begin
      special_res_o = QNAN_16;
    end else if (sign) begin
      special_res_o = QNAN_16;
    end else if (e == 8'hFF) begin
      special_res_o   = inv_i ? 16'h0000 : PINF_16;
      special_flags_o = 3'b000;
    end else begin
      special_o       = 1'b0;
      special_res_o   = 16'h0000;
      special_flags_o = 3'b000;
    end
  end

endmodule

// File: rtl/lamp_sqrt_issue_ctrl.sv
// Issue controller for the sqrt significand core: accepts an operand, issues
// the core command, captures the result pulse and repacks it on a valid/ready port.
module lamp_sqrt_issue_ctrl
  import lampFPU_pkg::*;
#(
  parameter int TIMEOUT_CYC = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [15:0] op_i,
  input  logic        inv_i,
  output logic        core_do_o,
  output logic [7:0]  core_s_o,
  output logic        core_exp_odd_o,
  output logic        core_inv_o,
  output logic        core_special_o,
  input  logic        core_valid_i,
  input  logic [7:0]  core_res_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [15:0] res_o,
  output logic [2:0]  flags_o
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  function automatic logic [15:0] renorm_pack(input logic [7:0] sig, input logic [7:0] e);
    if (sig[7]) return {1'b0, e, sig[6:0]};
    return {1'b0, e - 8'd1, sig[5:0], 1'b0};
  endfunction

  sqrt_ctrl_ss_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             cls_special;
  logic [15:0]      cls_res;
  logic [2:0]       cls_flags;
  logic [7:0]       cls_res_e;
  logic             cls_exp_odd;

  logic             spec_q;
  logic [15:0]      spec_res_q;
  logic [2:0]       spec_flags_q;
  logic [7:0]       res_e_q;
  logic [7:0]       raw_q;

  logic             accept, capture, timeout_hit, load_res;

  lamp_sqrt_classify u_classify (
    .op_i            (op_i),
    .inv_i           (inv_i),
    .special_o       (cls_special),
    .special_res_o   (cls_res),
    .special_flags_o (cls_flags),
    .res_e_o         (cls_res_e),
    .exp_odd_o       (cls_exp_odd)
  );

  assign req_ready_o = (state_q == IDLE);
  assign res_valid_o = (state_q == OUT);
  assign accept      = req_valid_i & req_ready_o;
  // done_q marks a captured result (or a special) awaiting its packing cycle.
  assign capture     = (state_q == WAIT) & ~done_q & core_valid_i;
  assign timeout_hit = (state_q == WAIT) & ~done_q & ~core_valid_i & (cnt_q == CNT_LAST);
  assign load_res    = (state_q == WAIT) & (done_q | timeout_hit);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE:  if (req_valid_i) state_d = ISSUE;
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
        done_d  = spec_q;
      end
      WAIT: begin
        if (load_res)     state_d = OUT;
        else if (capture) done_d  = 1'b1;
        else              cnt_d   = cnt_q + CNT_W'(1);
      end
      OUT: if (res_ready_i) begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      done_q         <= 1'b0;
      core_do_o      <= 1'b0;
      core_special_o <= 1'b0;
      core_s_o       <= 8'h00;
      core_exp_odd_o <= 1'b0;
      core_inv_o     <= 1'b0;
      res_o          <= 16'h0000;
      flags_o        <= 3'b000;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      done_q         <= done_d;
      core_do_o      <= accept & ~cls_special;
      core_special_o <= accept & cls_special;
      if (accept) begin
        core_s_o       <= {1'b1, op_i[6:0]};
        core_exp_odd_o <= cls_exp_odd;
        core_inv_o     <= inv_i;
      end
      if (load_res) begin
        res_o   <= done_q ? (spec_q ? spec_res_q : renorm_pack(raw_q, res_e_q)) : QNAN_16;
        flags_o <= done_q ? spec_flags_q : FLAG_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      spec_q       <= cls_special;
      spec_res_q   <= cls_res;
      spec_flags_q <= cls_flags;
      res_e_q      <= cls_res_e;
    end
    if (capture) raw_q <= core_res_i;
  end

endmodule
